// File: rtl/ifm_buf_pkg.sv
// ifm_buf_pkg -- shared types and helpers for the ping-pong IFM buffer.
//   c_state_t  : consumer handshake state (idle / start pulse / busy)
//   addr_width : $clog2 with a floor of 1 so single-word banks still get a port
//   NUM_BANKS  : number of physical banks (ping and pong)
package ifm_buf_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        C_IDLE,
        C_START,
        C_BUSY
    } c_state_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ifm_bank_ram.sv
// ifm_bank_ram -- one IFM bank: one write port, two independent synchronous
// read ports (producer accumulate and consumer), each with 1-cycle latency.
// A read and a write to the same address in one cycle return the old word.
// Ports:
//   clk                   rising-edge clock
//   we / waddr / wdata    write port
//   p_re / p_raddr        producer read request  -> p_rdata next cycle
//   c_re / c_raddr        consumer read request  -> c_rdata next cycle
// Addresses are assumed in range; range checks live in the parent.
module ifm_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 120,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  p_re,
    input  logic [ADDR_WIDTH-1:0] p_raddr,
    output logic [DATA_WIDTH-1:0] p_rdata,
    input  logic                  c_re,
    input  logic [ADDR_WIDTH-1:0] c_raddr,
    output logic [DATA_WIDTH-1:0] c_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read registers have no reset so they map onto
    // block RAM; the parent masks the read data to zero until the first read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // NOTE: non-blocking reads sample the pre-write contents, which is
        // exactly the read-before-write behaviour the accumulator relies on.
        if (p_re) begin
            p_rdata <= mem[p_raddr];
        end
        if (c_re) begin
            c_rdata <= mem[c_raddr];
        end
    end

endmodule

// File: rtl/ifm_pingpong_buffer.sv
// ifm_pingpong_buffer -- double-banked inter-layer IFM buffer.
// The producer fills (and read-modify-writes) wr_bank while the consumer
// reads rd_bank; full_count tracks how many banks are complete and unread.
// Ports:
//   clk, reset                       clock, async active-low reset
//   p_enable_write/p_address_write/p_data_in   producer write port
//   p_enable_read/p_address_read/p_data_out    producer read port (1 cycle)
//   p_start (in, pulse)              producer finished the write bank
//   p_end   (out, level)             a free write bank is available
//   c_start (out, pulse)             a bank is ready for the consumer
//   c_end   (in, pulse)              consumer finished with its bank
//   c_enable_read/c_address_read/c_data_out    consumer read port (1 cycle)
//   overflow (out, sticky)           p_start arrived with no free bank
// Build option: define IFM_CLEAR_ON_CONSUME_EN to zero each released bank,
// one word per cycle, before it can be written again.
module ifm_pingpong_buffer
    import ifm_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 120,
    parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_enable_write,
    input  logic [ADDR_WIDTH-1:0] p_address_write,
    input  logic [DATA_WIDTH-1:0] p_data_in,
    input  logic                  p_enable_read,
    input  logic [ADDR_WIDTH-1:0] p_address_read,
    output logic [DATA_WIDTH-1:0] p_data_out,
    input  logic                  p_start,
    output logic                  p_end,
    output logic                  c_start,
    input  logic                  c_end,
    input  logic                  c_enable_read,
    input  logic [ADDR_WIDTH-1:0] c_address_read,
    output logic [DATA_WIDTH-1:0] c_data_out,
    output logic                  overflow
);

    logic                  wr_bank;
    logic                  rd_bank;
    logic [1:0]            full_count;
    c_state_t              c_state;
    c_state_t              c_state_next;

    logic                  clearing;
    logic                  clr_bank;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  p_wr_in_range;
    logic                  p_rd_in_range;
    logic                  c_rd_in_range;
    logic                  p_wr_ok;
    logic                  p_start_ok;
    logic                  c_end_ok;

    logic                  p_sel_q;
    logic                  p_zero_q;
    logic                  c_sel_q;
    logic                  c_zero_q;

    logic                  bank_we      [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] bank_waddr   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_wdata   [NUM_BANKS];
    logic                  bank_p_re    [NUM_BANKS];
    logic                  bank_c_re    [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_p_rdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_c_rdata [NUM_BANKS];

    assign p_wr_in_range = int'(p_address_write) < DEPTH;
    assign p_rd_in_range = int'(p_address_read)  < DEPTH;
    assign c_rd_in_range = int'(c_address_read)  < DEPTH;

    // A bank being cleared is neither free nor full, so it counts against p_end.
    assign p_end      = (full_count + {1'b0, clearing}) < 2'd2;
    assign p_wr_ok    = p_enable_write && p_end && p_wr_in_range;
    assign p_start_ok = p_start && (full_count < 2'd2);
    assign c_end_ok   = c_end && (c_state == C_BUSY) && !clearing;

    // Bank pointers, occupancy and consumer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            full_count <= 2'd0;
            overflow   <= 1'b0;
            c_state    <= C_IDLE;
        end else begin
            c_state <= c_state_next;
            if (p_start_ok) wr_bank <= ~wr_bank;
            if (c_end_ok)   rd_bank <= ~rd_bank;
            if (p_start && !p_start_ok) overflow <= 1'b1;
            // Simultaneous fill and release leaves the occupancy unchanged.
            if (p_start_ok && !c_end_ok) begin
                full_count <= full_count + 2'd1;
            end else if (!p_start_ok && c_end_ok) begin
                full_count <= full_count - 2'd1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    always_comb begin
        c_state_next = c_state;
        c_start      = 1'b0;
        unique case (c_state)
            C_IDLE:  if (full_count != 2'd0) c_state_next = C_START;
            C_START: begin
                c_start      = 1'b1;
                c_state_next = C_BUSY;
            end
            C_BUSY:  if (c_end_ok) c_state_next = C_IDLE;
            default: c_state_next = C_IDLE;
        endcase
    end

`ifdef IFM_CLEAR_ON_CONSUME_EN
    // Zero the just-released bank, sweeping address 0..DEPTH-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clearing <= 1'b0;
            clr_bank <= 1'b0;
            clr_addr <= '0;
        end else if (c_end_ok) begin
            clearing <= 1'b1;
            clr_bank <= rd_bank;
            clr_addr <= '0;
        end else if (clearing) begin
            if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                clearing <= 1'b0;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end
`else
    assign clearing = 1'b0;
    assign clr_bank = 1'b0;
    assign clr_addr = '0;
`endif

    // Per-bank port steering; the clear sweep owns its bank's write port.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b]    = 1'b0;
            bank_waddr[b] = p_address_write;
            bank_wdata[b] = p_data_in;
            if (clearing && (clr_bank == 1'(b))) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = clr_addr;
                bank_wdata[b] = '0;
            end else if (p_wr_ok && (wr_bank == 1'(b))) begin
                bank_we[b] = 1'b1;
            end
            bank_p_re[b] = p_enable_read && p_rd_in_range && (wr_bank == 1'(b));
            bank_c_re[b] = c_enable_read && c_rd_in_range && (rd_bank == 1'(b));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ifm_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk     (clk),
            .we      (bank_we[b]),
            .waddr   (bank_waddr[b]),
            .wdata   (bank_wdata[b]),
            .p_re    (bank_p_re[b]),
            .p_raddr (p_address_read),
            .p_rdata (bank_p_rdata[b]),
            .c_re    (bank_c_re[b]),
            .c_raddr (c_address_read),
            .c_rdata (bank_c_rdata[b])
        );
    end

    // Remember which bank each read targeted (pointers may move before the
    // data is consumed) and whether it was out of range; zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_sel_q  <= 1'b0;
            p_zero_q <= 1'b1;
            c_sel_q  <= 1'b0;
            c_zero_q <= 1'b1;
        end else begin
            if (p_enable_read) begin
                p_sel_q  <= wr_bank;
                p_zero_q <= !p_rd_in_range;
            end
            if (c_enable_read) begin
                c_sel_q  <= rd_bank;
                c_zero_q <= !c_rd_in_range;
            end
        end
    end

    assign p_data_out = p_zero_q ? '0 : bank_p_rdata[p_sel_q];
    assign c_data_out = c_zero_q ? '0 : bank_c_rdata[c_sel_q];

endmodule

// File: doc/ifm_pingpong_buffer.md
Name: ifm_pingpong_buffer

Overview:
Double-banked inter-layer IFM buffer that sits between a producing conv layer and the consuming layer.
- Producer side: accepts the producer's next-layer write port, read-modify-write read port and start_to_next / end_from_next handshake.
- Consumer side: presents a start_from_previous / end_to_previous style handshake and a read port to the consuming layer.
- Ping-pong operation lets the producer fill one bank while the consumer reads the other.

Parameters:
DATA_WIDTH, 32, word width.
DEPTH, 120, words per bank (IFM_SIZE*IFM_SIZE*NUMBER_OF_IFM, flattened).
ADDR_WIDTH, $clog2(DEPTH) (minimum 1), address width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
p_enable_write  in  1  producer write strobe (ifm_enable_write_next).
p_address_write  in  ADDR_WIDTH  producer write address.
p_data_in  in  DATA_WIDTH  producer write data (data_out_for_next).
p_enable_read  in  1  producer read strobe for accumulation (ifm_enable_read_next).
p_address_read  in  ADDR_WIDTH  producer read address.
p_data_out  out  DATA_WIDTH  producer read data (data_in_from_next).
p_start  in  1  one-cycle pulse: write bank complete (start_to_next).
p_end  out  1  level: a free write bank is available (end_from_next).
c_start  out  1  one-cycle pulse: bank ready for consumer.
c_end  in  1  one-cycle pulse: consumer finished with bank.
c_enable_read  in  1  consumer read strobe.
c_address_read  in  ADDR_WIDTH  consumer read address.
c_data_out  out  DATA_WIDTH  consumer read data.
overflow  out  1  sticky: p_start received with no free bank.

Behaviour:
- Reset (reset low, async): wr_bank=0, rd_bank=0, full_count=0, consumer FSM=C_IDLE. Outputs: p_data_out=0, c_data_out=0, c_start=0, overflow=0, p_end=1. RAM contents are not reset.
- Producer writes and reads always target wr_bank. Consumer reads always target rd_bank.
- Read latency is 1 cycle on both ports. Data is registered on the strobe. Output holds its last value when the strobe is low.
- Read at address >= DEPTH returns 0. Write at address >= DEPTH is ignored.
- Producer read and write to the same address in the same cycle returns the old data (read-before-write).
- p_end = (full_count < 2), combinational from registered state.
- Writes while p_end=0 are dropped.
- p_start with full_count<2: wr_bank toggles, full_count++.
- p_start with full_count==2: ignored; overflow set (sticky until reset).
- Consumer FSM:
  - C_IDLE: if full_count>0, go to C_START.
  - C_START: c_start=1 for exactly one cycle, then go to C_BUSY.
  - C_BUSY: on c_end, rd_bank toggles, full_count--, go to C_IDLE.
- c_end in C_IDLE or C_START is ignored.
- Simultaneous p_start and accepted c_end: both bank pointers toggle, full_count unchanged.
- Minimum gap from p_start to c_start is 2 cycles (IDLE→START).

Optional Feature:
IFM_CLEAR_ON_CONSUME_EN
- Defined: on accepted c_end, the released bank is zeroed, one word per cycle, over DEPTH cycles.
  - A CLEARING flag holds that bank non-free: p_end uses (full_count + clearing) < 2.
  - A second c_end during an active clear is stalled (ignored) until the clear completes.
  - Effect: producer accumulation always starts from 0.
- Undefined: no clear logic; released banks keep stale data, and the producer must write before read-accumulate.

Decomposition:
- Package ifm_buf_pkg:
  - consumer state enum {C_IDLE, C_START, C_BUSY};
  - function addr_width(depth), clog2 with minimum 1;
  - localparam NUM_BANKS=2.
- Sub-module ifm_bank_ram:
  - one bank: one write port and two synchronous read ports (producer and consumer), 1-cycle registered read;
  - instantiated twice;
  - mux/bank-select logic stays in the top.

Test Plan:
1. Reset low mid-fill (after writing addr 0..9), then release → p_end=1, c_start=0, overflow=0, full_count=0; new writes land in bank 0.
2. Write addr k=k+100 for k=0..119, pulse p_start → c_start pulses exactly 2 cycles later. Consumer reads addr 5 → c_data_out=105 one cycle after strobe.
3. Fill bank0, p_start; fill bank1 with 200+k, p_start → p_end=0. Writes to addr 0 are dropped. A third p_start sets overflow=1. After c_end, p_end=1 and c_start pulses for bank1; read addr 0 → 200.
4. Producer read-modify-write: write addr 3=7, read addr 3 while writing addr 3=9 same cycle → p_data_out=7; next read → 9.
5. Same-cycle p_start and c_end with full_count=1 → full_count stays 1, both pointers toggle, next c_start serves the just-completed bank.
6. With IFM_CLEAR_ON_CONSUME_EN: c_end on a bank holding 0xFFFF_FFFF → p_end held 0 for 120 cycles when the other bank is full; after that, producer reads of any address → 0.
